// File: rtl/boa_dma_pkg.sv
// Shared types and constants for the mem_dma copy engine.
//   dma_state_t : engine FSM states
//   WORD_BE     : byte-enable pattern for a full 32-bit word write
package boa_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        FIN
    } dma_state_t;

    localparam logic [3:0] WORD_BE = 4'hF;

endpackage

// File: rtl/mem_dma.sv
// mem_dma: word-granular memory-to-memory copy engine acting as the initiator on a boa memory bus.
// A one-cycle start latches the source/destination word addresses and a word count. The engine
// then reads each source word, captures it, and writes it to the destination, in ascending order.
//
// Ports:
//   clk, rst            memory clock, synchronous active-high reset
//   start               start pulse, ignored unless idle
//   src_addr, dst_addr  byte addresses; bits [1:0] ignored
//   len                 number of 32-bit words to copy
//   busy, done          busy while transferring, one-cycle done pulse on completion
//   re, we, addr, wdata bus request outputs (initiator side)
//   rdata, ready        bus response inputs
//
// Optional feature (macro BOA_DMA_FILL_EN): adds fill and fill_data inputs, sampled with start.
// In fill mode the read phase is skipped and fill_data is written to every destination word.
module mem_dma
    import boa_dma_pkg::*;
#(
    parameter int unsigned len_bits = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [len_bits-1:0] len,
`ifdef BOA_DMA_FILL_EN
    input  logic                fill,
    input  logic [31:0]         fill_data,
`endif
    output logic                busy,
    output logic                done,
    output logic                re,
    output logic [3:0]          we,
    output logic [31:0]         addr,
    output logic [31:0]         wdata,
    input  logic [31:0]         rdata,
    input  logic                ready
);

    dma_state_t          state_q, state_d;
    logic [29:0]         src_q, src_d;
    logic [29:0]         dst_q, dst_d;
    logic [len_bits-1:0] count_q, count_d;
    logic [31:0]         buf_q, buf_d;
`ifdef BOA_DMA_FILL_EN
    logic                fill_q, fill_d;
`endif

    // Byte-offset bits of the addresses carry no information for word transfers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
`ifdef BOA_DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            buf_q   <= buf_d;
`ifdef BOA_DMA_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    // Bus outputs decode straight from registered state, so ready=0 holds them unchanged.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        buf_d   = buf_q;
`ifdef BOA_DMA_FILL_EN
        fill_d  = fill_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;
        re      = 1'b0;
        we      = 4'h0;
        addr    = 32'h0;
        wdata   = 32'h0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr[31:2];
                    dst_d   = dst_addr[31:2];
                    count_d = len;
`ifdef BOA_DMA_FILL_EN
                    fill_d  = fill;
                    // Fill data rides in the buffer so WRITE needs no extra mux.
                    if (fill) begin
                        buf_d = fill_data;
                    end
                    if (len == '0) begin
                        state_d = FIN;
                    end else if (fill) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
`else
                    if (len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = READ;
                    end
`endif
                end
            end
            READ: begin
                busy = 1'b1;
                re   = 1'b1;
                addr = {src_q, 2'b00};
                if (ready) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                busy    = 1'b1;
                buf_d   = rdata;
                state_d = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                we    = WORD_BE;
                addr  = {dst_q, 2'b00};
                wdata = buf_q;
                if (ready) begin
                    // 30-bit pointers wrap naturally past the top of the address space.
                    src_d   = src_q + 30'd1;
                    dst_d   = dst_q + 30'd1;
                    count_d = count_q - len_bits'(1);
                    if (count_q == len_bits'(1)) begin
                        state_d = FIN;
`ifdef BOA_DMA_FILL_EN
                    end else if (fill_q) begin
                        state_d = WRITE;
`endif
                    end else begin
                        state_d = READ;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma. A behavioural word memory (index = addr[11:2]) answers bus
// requests with rdata valid the cycle after acceptance; ready can be toggled every cycle.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] len = 16'h0;
`ifdef BOA_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [31:0] fill_data = 32'h0;
    logic        fill_mode = 1'b0;
    logic [31:0] fill_word = 32'h0;
`endif
    logic        busy;
    logic        done;
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        ready = 1'b1;

    logic        alt_ready = 1'b0;
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = 10'h0;
    logic [31:0] pre_data = 32'h0;
    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_fail = 0;

    // Results of the most recent run
    int          done_cyc, busy_cnt, done_cnt, re_cnt, we_cnt, hold_bad, both_bad, wr_n;
    logic [31:0] rd_first;
    logic [31:0] wr_log [0:15];

    mem_dma #(.len_bits(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
`ifdef BOA_DMA_FILL_EN
        .fill     (fill),
        .fill_data(fill_data),
`endif
        .busy     (busy),
        .done     (done),
        .re       (re),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alt_ready) ready <= ~ready;
        else           ready <= 1'b1;
        if (ready && re)         rdata <= mem[addr[11:2]];
        if (ready && we == 4'hF) mem[addr[11:2]] <= wdata;
        if (pre_we)              mem[pre_idx] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Pulse start (this cycle = cycle 0), then observe ncyc cycles. Called #1 after an edge.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int ncyc);
        logic        p_strobe;
        logic        p_ready;
        logic [68:0] p_bus;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; re_cnt = 0; we_cnt = 0;
        hold_bad = 0; both_bad = 0; wr_n = 0; rd_first = 32'hDEAD_0000;
        p_strobe = 1'b0; p_ready = 1'b1; p_bus = '0;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
`ifdef BOA_DMA_FILL_EN
        fill = fill_mode; fill_data = fill_word;
`endif
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            // Scramble inputs after acceptance; the engine must have latched them.
            start = 1'b0; src_addr = 32'hFFFF_FFF0; dst_addr = 32'hFFFF_FFF0; len = 16'hFFFF;
`ifdef BOA_DMA_FILL_EN
            fill = ~fill_mode; fill_data = 32'h0BAD_0BAD;
`endif
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (re) begin
                if (re_cnt == 0) rd_first = addr;
                re_cnt++;
            end
            if (we != 4'h0) begin
                we_cnt++;
                if (ready && wr_n < 16) begin
                    wr_log[wr_n] = addr;
                    wr_n++;
                end
            end
            if (re && we != 4'h0) both_bad++;
            if (p_strobe && !p_ready && {re, we, addr, wdata} != p_bus) hold_bad++;
            p_strobe = re || (we != 4'h0);
            p_ready  = ready;
            p_bus    = {re, we, addr, wdata};
        end
    endtask

    initial begin
        int k;
        int dn;
        int bz;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_re", {31'h0, re}, 32'h0);
        check("rst_we", {28'h0, we}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        preload(10'h000, 32'h1111_1111);
        preload(10'h001, 32'h2222_2222);
        preload(10'h002, 32'h3333_3333);
        preload(10'h003, 32'h4444_4444);
        preload(10'h010, 32'hA5A5_A5A5);
        preload(10'h011, 32'h5A5A_0001);

        // Basic copy: 4 words 0x000 -> 0x100
        run(32'h0000_0000, 32'h0000_0100, 16'd4, 20);
        check("basic_done_cyc", done_cyc, 32'd13);
        check("basic_busy_cnt", busy_cnt, 32'd12);
        check("basic_done_cnt", done_cnt, 32'd1);
        check("basic_re_cnt", re_cnt, 32'd4);
        check("basic_we_cnt", we_cnt, 32'd4);
        check("basic_both", both_bad, 32'd0);
        check("basic_w0", mem[10'h040], 32'h1111_1111);
        check("basic_w1", mem[10'h041], 32'h2222_2222);
        check("basic_w2", mem[10'h042], 32'h3333_3333);
        check("basic_w3", mem[10'h043], 32'h4444_4444);

        // len = 0
        run(32'h0000_0040, 32'h0000_0140, 16'd0, 6);
        check("len0_done_cyc", done_cyc, 32'd1);
        check("len0_done_cnt", done_cnt, 32'd1);
        check("len0_busy_cnt", busy_cnt, 32'd0);
        check("len0_strobes", re_cnt + we_cnt, 32'd0);

        // Wait states: ready toggles every cycle
        alt_ready = 1'b1;
        run(32'h0000_0040, 32'h0000_0140, 16'd2, 30);
        alt_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_done_seen", {31'h0, done_cyc != 0}, 32'h1);
        check("wait_done_cnt", done_cnt, 32'd1);
        check("wait_hold", hold_bad, 32'd0);
        check("wait_both", both_bad, 32'd0);
        check("wait_w0", mem[10'h050], 32'hA5A5_A5A5);
        check("wait_w1", mem[10'h051], 32'h5A5A_0001);

        // Unaligned addresses are forced to word alignment
        run(32'h0000_0003, 32'h0000_0183, 16'd1, 8);
        check("unal_rd_addr", rd_first, 32'h0000_0000);
        check("unal_wr_addr", wr_log[0], 32'h0000_0180);
        check("unal_data", mem[10'h060], 32'h1111_1111);
        check("unal_done_cyc", done_cyc, 32'd4);

        // Destination pointer wraps from 0xFFFFFFFC to 0x00000000
        run(32'h0000_0008, 32'hFFFF_FFFC, 16'd2, 12);
        check("wrap_wr_n", wr_n, 32'd2);
        check("wrap_wr0", wr_log[0], 32'hFFFF_FFFC);
        check("wrap_wr1", wr_log[1], 32'h0000_0000);
        check("wrap_d0", mem[10'h3FF], 32'h3333_3333);
        check("wrap_d1", mem[10'h000], 32'h4444_4444);

        // Reset during the first WRITE of a len=8 copy
        src_addr = 32'h0; dst_addr = 32'h300; len = 16'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (we == 4'h0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("rstmid_write_cyc", k, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_re", {31'h0, re}, 32'h0);
        check("rstmid_we", {28'h0, we}, 32'h0);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        dn = 0;
        bz = 0;
        repeat (10) begin
            if (done) dn++;
            if (busy) bz++;
            @(posedge clk); #1;
        end
        check("rstmid_no_done", dn, 32'd0);
        check("rstmid_idle", bz, 32'd0);

        // Fresh copy after the abandoned one
        run(32'h0000_0000, 32'h0000_01C0, 16'd2, 12);
        check("after_done_cyc", done_cyc, 32'd7);
        check("after_w0", mem[10'h070], 32'h4444_4444);
        check("after_w1", mem[10'h071], 32'h2222_2222);

`ifdef BOA_DMA_FILL_EN
        fill_mode = 1'b1;
        fill_word = 32'hDEAD_BEEF;
        run(32'h0000_0123, 32'h0000_0200, 16'd3, 10);
        fill_mode = 1'b0;
        check("fill_done_cyc", done_cyc, 32'd4);
        check("fill_re_cnt", re_cnt, 32'd0);
        check("fill_we_cnt", we_cnt, 32'd3);
        check("fill_w0", mem[10'h080], 32'hDEAD_BEEF);
        check("fill_w1", mem[10'h081], 32'hDEAD_BEEF);
        check("fill_w2", mem[10'h082], 32'hDEAD_BEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Word-granular memory-to-memory copy engine.
- Acts as the initiator (boa_mem_bus.CPU side) on a boa memory bus. It drives read and write requests into block RAMs, ROMs and other boa_mem_bus.MEM responders.
- Started by a one-cycle start pulse from a control block. Reports completion with busy and a one-cycle done pulse.
- Sits beside the CPU data port, behind the bus arbiter.

Parameters:
- len_bits, 16, width of the word-count input; max transfer is 2^len_bits-1 words.

Ports:
- clk  input  1  memory clock
- rst  input  1  synchronous active-high reset
- start  input  1  start pulse; ignored unless idle
- src_addr  input  32  source byte address; bits [1:0] ignored (forced word-aligned)
- dst_addr  input  32  destination byte address; bits [1:0] ignored
- len  input  len_bits  number of 32-bit words to copy
- busy  output  1  high from the cycle after accepted start until done is pulsed
- done  output  1  one-cycle completion pulse
- bus  interface  -  boa_mem_bus.CPU: re, we[3:0], addr[31:0], wdata[31:0] driven; rdata[31:0], ready sampled

Behaviour:
- Bus protocol:
  - A request (re=1, or we!=0) holds addr, wdata and we stable until a cycle in which ready=1; that cycle accepts the request.
  - Read data is valid on rdata in the cycle after acceptance.
  - re and we are never both asserted.
- Reset: state IDLE, busy=0, done=0, re=0, we=0, addr=0, wdata=0. Internal pointers, count and buffer are cleared.
- Reset mid-operation: abandons the transfer. Strobes are 0 from the first clock edge at which rst is sampled high. No done pulse is produced.
- FSM states: IDLE, READ, CAPT, WRITE, FIN.
- IDLE:
  - On start=1, latch src_addr[31:2], dst_addr[31:2] and len.
  - If len==0, go to FIN. Otherwise go to READ.
- READ: re=1, addr={src_ptr,2'b00}. When ready=1, go to CAPT.
- CAPT: register rdata into the buffer, go to WRITE. No strobes are asserted in this state.
- WRITE:
  - Drive we=4'hF, addr={dst_ptr,2'b00}, wdata=buffer.
  - When ready=1: src_ptr+=1, dst_ptr+=1, count-=1.
  - If count was 1, go to FIN. Otherwise go to READ.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- busy=1 in READ, CAPT and WRITE only.
- Throughput: 3 cycles per word when ready is always high. Latency from start to done for N words is 3N+1 cycles.
- Word pointers are 30 bits and wrap modulo 2^30 (address 0xFFFFFFFC is followed by 0x00000000).
- Overlap: the copy is strictly ascending, word by word. If regions overlap with dst>src, the result reflects already-written words. This is defined behaviour, not an error.
- start while busy or in FIN is ignored. Input changes after acceptance have no effect.
- Wait states: ready=0 holds the current state and all bus outputs unchanged, for any number of cycles.

Optional Feature:
- Macro: BOA_DMA_FILL_EN.
- When defined:
  - Adds ports fill (input 1) and fill_data (input 32), sampled with start.
  - If fill=1, READ and CAPT are skipped. WRITE writes the latched fill_data to each destination word, giving 1 cycle per word when ready is high.
  - src_addr is ignored in fill mode.
  - Latency for N words is N+1 cycles.
- When not defined: the fill and fill_data ports are absent, and behaviour is copy-only as above.

Decomposition:
- Package boa_dma_pkg holds:
  - typedef enum logic [2:0] dma_state_t {IDLE, READ, CAPT, WRITE, FIN}
  - constant WORD_BE = 4'hF
- No sub-module: a single FSM plus datapath registers.
- Bench pairs the engine with block_ram instances as responders.

Test Plan:
- Basic copy: block_ram preloaded with 0x11111111..0x44444444 at 0x000..0x00C; start src=0x000, dst=0x100, len=4 -> words 0x100..0x10C match; done 13 cycles after start; busy high for 12 cycles.
- len=0: start with len=0 -> done pulses 1 cycle after start; no re/we ever asserted.
- Wait states: responder drops ready on alternate cycles, len=2 -> strobes and addr held stable while ready=0; data is correct; done is pulsed once.
- Unaligned and wrap:
  - src=0x003, len=1 -> reads 0x000.
  - dst=0xFFFFFFFC, len=2 -> writes 0xFFFFFFFC then 0x00000000.
- Reset mid-copy: rst asserted in a WRITE cycle of a len=8 copy -> re=we=0 from the next edge, no done, busy=0; a new start afterwards completes normally.
- BOA_DMA_FILL_EN: fill=1, fill_data=0xDEADBEEF, dst=0x200, len=3 -> three words equal 0xDEADBEEF; re never asserted; done 4 cycles after start.
